// File: rtl/taxi_axis_join_pkg.sv
// Shared types and constants for the AXI4-Stream join block.
// The optional tlast resynchronisation feature is enabled with TAXI_AXIS_JOIN_RESYNC_EN.
package taxi_axis_join_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/taxi_axis_join_if.sv
// AXI4-Stream bus bundle with optional sideband fields.
// Disabled fields are still present so all users share one signal set.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit STRB_EN = 1'b0,
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid, input tready);
    modport snk (input tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/taxi_axis_join_skid.sv
// Registered skid pair: output register plus one temp register.
// in_ready is registered, so the upstream never sees out_ready combinationally.
module taxi_axis_join_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] tmp_data;
    logic         tmp_valid;
    logic         out_valid_next, tmp_valid_next, ready_early;
    logic         load_out_in, load_tmp_in, load_out_tmp;

    // Route the incoming beat to output or temp, and refill output from temp.
    always_comb begin
        out_valid_next = out_valid;
        tmp_valid_next = tmp_valid;
        load_out_in    = 1'b0;
        load_tmp_in    = 1'b0;
        load_out_tmp   = 1'b0;
        // Ready next cycle unless temp is full or about to be filled by a stall.
        ready_early    = out_ready || (!tmp_valid && (!out_valid || !in_valid));
        if (in_ready) begin
            if (out_ready || !out_valid) begin
                out_valid_next = in_valid;
                load_out_in    = 1'b1;
            end else begin
                tmp_valid_next = in_valid;
                load_tmp_in    = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_next = tmp_valid;
            tmp_valid_next = 1'b0;
            load_out_tmp   = 1'b1;
        end
    end

    // Control flags: cleared by reset so buffered beats are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            tmp_valid <= 1'b0;
        end else begin
            in_ready  <= ready_early;
            out_valid <= out_valid_next;
            tmp_valid <= tmp_valid_next;
        end
    end

    // Data registers carry no reset; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (load_out_in)       out_data <= in_data;
        else if (load_out_tmp) out_data <= tmp_data;
        if (load_tmp_in)       tmp_data <= in_data;
    end

endmodule

// File: rtl/taxi_axis_join.sv
// Joins S_COUNT AXI4-Stream lanes into one wide stream, lane 0 in the LSB slice.
// Define TAXI_AXIS_JOIN_RESYNC_EN to detect tlast misalignment and resynchronise lanes.
module taxi_axis_join
    import taxi_axis_join_pkg::*;
#(
    parameter int S_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis [S_COUNT],
    taxi_axis_if.src         m_axis,
    output logic             stat_mismatch,
    output logic [CNT_W-1:0] stat_mismatch_cnt
);
    localparam int DATA_W   = s_axis[0].DATA_W;
    localparam int KEEP_W   = s_axis[0].KEEP_W;
    localparam int M_DATA_W = m_axis.DATA_W;
    localparam int M_KEEP_W = m_axis.KEEP_W;
    localparam int ID_W     = m_axis.ID_W;
    localparam int DEST_W   = m_axis.DEST_W;
    localparam int USER_W   = m_axis.USER_W;
    localparam bit KEEP_EN  = m_axis.KEEP_EN;
    localparam bit STRB_EN  = m_axis.STRB_EN;
    localparam bit LAST_EN  = m_axis.LAST_EN;
    localparam bit ID_EN    = m_axis.ID_EN;
    localparam bit DEST_EN  = m_axis.DEST_EN;
    localparam bit USER_EN  = m_axis.USER_EN;
    localparam int BEAT_W   = M_DATA_W + 2*M_KEEP_W + ID_W + DEST_W + USER_W + 1;

    if (S_COUNT < 2) begin : g_err_count
        $fatal(1, "taxi_axis_join: S_COUNT must be at least 2");
    end
    if (M_DATA_W != S_COUNT*DATA_W) begin : g_err_data
        $fatal(1, "taxi_axis_join: m_axis.DATA_W must equal S_COUNT*s_axis.DATA_W");
    end
    if ((KEEP_EN || STRB_EN) && M_KEEP_W != S_COUNT*KEEP_W) begin : g_err_keep
        $fatal(1, "taxi_axis_join: m_axis.KEEP_W must equal S_COUNT*s_axis.KEEP_W");
    end
    if ((ID_EN && s_axis[0].ID_W != ID_W) || (DEST_EN && s_axis[0].DEST_W != DEST_W) ||
        (USER_EN && s_axis[0].USER_W != USER_W)) begin : g_err_side
        $fatal(1, "taxi_axis_join: lane and output sideband widths differ");
    end

    logic [S_COUNT-1:0]             lane_valid, lane_last, lane_ready;
    logic [S_COUNT-1:0][DATA_W-1:0] lane_data;
    logic [S_COUNT-1:0][KEEP_W-1:0] lane_keep, lane_strb;
    logic [S_COUNT-1:0][USER_W-1:0] lane_user;
    logic [ID_W-1:0]                lane0_id;
    logic [DEST_W-1:0]              lane0_dest;

    for (genvar n = 0; n < S_COUNT; n++) begin : g_lane
        assign lane_valid[n]     = s_axis[n].tvalid;
        assign lane_last[n]      = s_axis[n].tlast;
        assign lane_data[n]      = s_axis[n].tdata;
        assign lane_keep[n]      = s_axis[n].tkeep;
        assign lane_strb[n]      = s_axis[n].tstrb;
        assign lane_user[n]      = s_axis[n].tuser;
        assign s_axis[n].tready  = lane_ready[n];
    end
    assign lane0_id   = s_axis[0].tid;
    assign lane0_dest = s_axis[0].tdest;

    state_t             state;
    logic [S_COUNT-1:0] pending;
    logic               misalign_en;
    logic               all_valid, join_valid, skid_ready;

    assign all_valid  = &lane_valid;
    assign join_valid = (state == ST_PASS) && all_valid;

    // ---- beat assembly ----
    logic [M_KEEP_W-1:0] b_keep, b_strb;
    logic [ID_W-1:0]     b_id;
    logic [DEST_W-1:0]   b_dest;
    logic [USER_W-1:0]   b_user, user_or;
    logic                b_last;
    logic [BEAT_W-1:0]   beat_in, beat_out;

    if (KEEP_EN) begin : g_keep
        assign b_keep = lane_keep;
    end else begin : g_nokeep
        assign b_keep = '1;
    end
    if (STRB_EN) begin : g_strb
        assign b_strb = lane_strb;
    end else begin : g_nostrb
        assign b_strb = b_keep;
    end

    assign b_id   = ID_EN   ? lane0_id   : '0;
    assign b_dest = DEST_EN ? lane0_dest : '0;
    assign b_last = LAST_EN ? (lane_last[0] | misalign_en) : 1'b1;

    // OR-combine user bits; a misaligned beat is flagged in bit 0.
    always_comb begin
        user_or = '0;
        for (int n = 0; n < S_COUNT; n++) user_or |= lane_user[n];
        b_user = '0;
        if (USER_EN) begin
            b_user = user_or;
            if (misalign_en) b_user[0] = 1'b1;
        end
    end

    assign beat_in = {lane_data, b_keep, b_strb, b_id, b_dest, b_user, b_last};

    taxi_axis_join_skid #(.W(BEAT_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (beat_in),
        .in_valid  (join_valid),
        .in_ready  (skid_ready),
        .out_data  (beat_out),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready)
    );

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tstrb, m_axis.tid,
            m_axis.tdest, m_axis.tuser, m_axis.tlast} = beat_out;

    // Lanes consume together only when every lane has data; during resync only pending lanes drain.
    always_comb begin
        lane_ready = {S_COUNT{skid_ready && all_valid}};
        if (state == ST_RESYNC) lane_ready = pending;
    end

`ifdef TAXI_AXIS_JOIN_RESYNC_EN
    state_t             state_next;
    logic [S_COUNT-1:0] pending_next;
    logic               mismatch_fire;

    assign misalign_en   = (state == ST_PASS) && !(&lane_last) && (|lane_last);
    assign mismatch_fire = join_valid && skid_ready && misalign_en;

    // State, pending set and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_PASS;
            pending           <= '0;
            stat_mismatch     <= 1'b0;
            stat_mismatch_cnt <= '0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            stat_mismatch <= mismatch_fire;
            if (mismatch_fire) stat_mismatch_cnt <= sat_inc(stat_mismatch_cnt);
        end
    end

    // Enter resync on a misaligned join; leave once every pending lane has seen its tlast.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            ST_PASS: begin
                if (mismatch_fire) begin
                    pending_next = ~lane_last;
                    state_next   = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                pending_next = pending & ~(lane_valid & lane_last);
                if (pending_next == '0) state_next = ST_PASS;
            end
            default: state_next = ST_PASS;
        endcase
    end
`else
    assign state             = ST_PASS;
    assign pending           = '0;
    assign misalign_en       = 1'b0;
    assign stat_mismatch     = 1'b0;
    assign stat_mismatch_cnt = '0;
`endif

endmodule

// File: doc/taxi_axis_join.md
TAXI_AXIS_JOIN -- requirements
Module: taxi_axis_join

Interface
REQ-001 Parameter S_COUNT, default 4, number of AXI4-Stream inputs to join; SHALL be at least 2.
REQ-002 Port clk, input, 1, sole clock; all logic SHALL be synchronous to its rising edge.
REQ-003 Port rst_n, input, 1; the block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-004 Port s_axis[S_COUNT], taxi_axis_if.snk, per-lane DATA_W, input lanes.
REQ-005 Port m_axis, taxi_axis_if.src, S_COUNT*DATA_W, joined output stream.
REQ-006 Port stat_mismatch, output, 1, one-cycle pulse per detected tlast misalignment.
REQ-007 Port stat_mismatch_cnt, output, 16, saturating count of mismatches.

Function
REQ-008 Elaboration SHALL be fatal if m_axis.DATA_W != S_COUNT*s_axis[0].DATA_W, or if KEEP_EN is set and m_axis.KEEP_W != S_COUNT*s_axis[0].KEEP_W.
REQ-009 Join beat: fires only when every s_axis[n].tvalid=1 and the output stage accepts; all lanes consume in the same cycle.
REQ-010 Output mapping: tdata/tkeep/tstrb = lane n in slice n (lane 0 LSB); tid/tdest = lane 0; tuser = bitwise OR of lane tuser; tlast = lane 0 tlast.
REQ-011 Disabled sideband fields SHALL be driven as: tkeep all-ones, tstrb=tkeep, tlast 1, tid/tdest/tuser 0.
REQ-012 Output stage SHALL be a registered skid pair (output reg + temp reg); latency input-to-output 1 cycle, sustained throughput 1 beat/cycle.
REQ-013 s_axis[n].tready SHALL be registered and identical for all lanes in PASS state; it never depends combinationally on m_axis.tready.
REQ-014 No beat SHALL be dropped, duplicated or reordered while in PASS state under arbitrary m_axis.tready backpressure.
REQ-015 FSM states: PASS, RESYNC.
REQ-016 PASS: on a join beat whose lane tlast bits are not all equal, emit the beat with tlast=1 and tuser bit 0 forced to 1, pulse stat_mismatch, increment stat_mismatch_cnt (saturating at 0xFFFF), latch set of lanes with tlast=0 as pending, go RESYNC.
REQ-017 RESYNC: pending lanes get tready=1 and beats are discarded until each lane's own tlast beat; non-pending lanes hold tready=0; no output beats generated.
REQ-018 RESYNC to PASS when pending set is empty; next join beat may fire no earlier than the following cycle.
REQ-019 Simultaneous tlast on the last pending lanes in one cycle SHALL clear all of them in that cycle.
REQ-020 Output beats already in the skid pair on entry to RESYNC SHALL still be delivered.

Reset
REQ-021 While rst_n=0 at a clock edge: m_axis.tvalid=0, all s_axis tready=0, temp valid=0, state=PASS, pending=0, stat_mismatch=0, stat_mismatch_cnt=0.
REQ-022 Reset mid-frame or mid-RESYNC SHALL discard buffered beats; datapath registers need no reset.
REQ-023 First tready assertion SHALL occur no earlier than the first edge after rst_n returns to 1.

Configuration
REQ-024 Macro TAXI_AXIS_JOIN_RESYNC_EN: defined, REQ-016..REQ-019 apply.
REQ-025 Undefined: FSM stays in PASS, tlast = lane 0 only, misalignment ignored, stat_mismatch and stat_mismatch_cnt tied 0.

Structure
REQ-026 Package taxi_axis_join_pkg SHALL hold the FSM state enum and the counter width constant (16).
REQ-027 Sub-module taxi_axis_join_skid SHALL implement the output skid pair; control/FSM stays in the top.

Verification
REQ-028 S_COUNT=4, DATA_W=8, lanes send 0x11,0x22,0x33,0x44 one beat -> m_axis.tdata=0x44332211 one cycle after acceptance.
REQ-029 Lane 2 tvalid withheld 5 cycles, others valid -> no output, lanes 0/1/3 not consumed; output follows 1 cycle after lane 2 valid.
REQ-030 Random m_axis.tready (50%), 1000 beats -> output sequence equals joined input sequence, no loss or duplication.
REQ-031 Macro defined: lane 1 tlast on beat 2, others on beat 4 -> beat 2 output tlast=1, tuser[0]=1, stat_mismatch 1 cycle, cnt=1; lanes 0/2/3 beats 3-4 discarded; next frame joins cleanly.
REQ-032 Macro undefined, same stimulus -> tlast follows lane 0, stat outputs remain 0.
REQ-033 rst_n low during RESYNC with output stalled -> next cycle tvalid=0, tready=0, cnt=0, state PASS.
